// File: rtl/pipelined_skip_subtractor_pkg.sv
// ============================================================================
// Module   : pipelined_skip_subtractor_pkg
// Brief    : Shared widths and split point for the pipelined carry-skip subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipelined_skip_subtractor_pkg;
   localparam int c_DATA_W = 16;
   localparam int c_BLK_W  = 4;
   localparam int c_SPLIT  = 8;

   typedef logic [c_DATA_W-1:0] data_t;
   typedef logic [c_SPLIT-1:0]  half_t;
   typedef logic [c_BLK_W-1:0]  blk_t;
endpackage

`default_nettype wire

// File: rtl/pipelined_skip_subtractor_if.sv
// ============================================================================
// Module   : pipelined_skip_subtractor_if
// Brief    : Operand/result handshake bundle. Overflow exists only with SUB_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_skip_subtractor_if;
   import pipelined_skip_subtractor_pkg::*;

   logic  in_valid;
   logic  in_ready;
   data_t operand1;
   data_t operand2;
   logic  out_valid;
   logic  out_ready;
   data_t Result;
   logic  Borrow;
`ifdef SUB_OVERFLOW_EN
   logic  Overflow;

   modport master (
      output in_valid, operand1, operand2, out_ready,
      input  in_ready, out_valid, Result, Borrow, Overflow
   );
   modport slave (
      input  in_valid, operand1, operand2, out_ready,
      output in_ready, out_valid, Result, Borrow, Overflow
   );
`else
   modport master (
      output in_valid, operand1, operand2, out_ready,
      input  in_ready, out_valid, Result, Borrow
   );
   modport slave (
      input  in_valid, operand1, operand2, out_ready,
      output in_ready, out_valid, Result, Borrow
   );
`endif
endinterface

`default_nettype wire

// File: rtl/pipelined_skip_subtractor_carry_skip_block4.sv
// ============================================================================
// Module   : carry_skip_block4
// Brief    : 4-bit ripple adder whose carry-in bypasses to carry-out when all bits propagate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_skip_block4
   import pipelined_skip_subtractor_pkg::*;
(
   input  wire blk_t a,
   input  wire blk_t b,
   input  wire logic cin,
   output blk_t      sum,
   output logic      cout
);
   blk_t             w_p;
   blk_t             w_g;
   logic [c_BLK_W:0] w_c;

   assign w_p    = a ^ b;
   assign w_g    = a & b;
   assign w_c[0] = cin;

   generate
      for (genvar k = 0; k < c_BLK_W; k++) begin : g_ripple
         assign w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
      end
   endgenerate

   assign sum  = w_p ^ w_c[c_BLK_W-1:0];
   assign cout = (&w_p) ? cin : w_c[c_BLK_W];
endmodule

`default_nettype wire

// File: rtl/pipelined_skip_subtractor.sv
// ============================================================================
// Module   : pipelined_skip_subtractor
// Brief    : Two-stage 16-bit subtractor (op1 + ~op2 + 1) built from carry-skip blocks,
//            valid/ready handshake on both sides. Macro SUB_OVERFLOW_EN adds Overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_skip_subtractor
   import pipelined_skip_subtractor_pkg::*;
(
   input  wire logic                    clk,
   input  wire logic                    rst,
   pipelined_skip_subtractor_if.slave   bus
);
   logic  w_load_a, w_load_b;
   data_t w_nop2;
   half_t w_sum_lo, w_sum_hi;
   logic  w_c4, w_c8, w_c12, w_c16;

   logic  r_valid_a, r_valid_b;
   half_t r_res_lo, r_op1_hi, r_nop2_hi;
   logic  r_c8;
   data_t r_result;
   logic  r_borrow;

   // Stage B frees up whenever its result leaves; stage A rides on that.
   assign w_load_b = !r_valid_b || bus.out_ready;
   assign w_load_a = !r_valid_a || w_load_b;
   assign w_nop2   = ~bus.operand2;

   carry_skip_block4 u_blk0 (.a(bus.operand1[3:0]),  .b(w_nop2[3:0]),  .cin(1'b1),
                             .sum(w_sum_lo[3:0]),    .cout(w_c4));
   carry_skip_block4 u_blk1 (.a(bus.operand1[7:4]),  .b(w_nop2[7:4]),  .cin(w_c4),
                             .sum(w_sum_lo[7:4]),    .cout(w_c8));
   carry_skip_block4 u_blk2 (.a(r_op1_hi[3:0]),      .b(r_nop2_hi[3:0]), .cin(r_c8),
                             .sum(w_sum_hi[3:0]),    .cout(w_c12));
   carry_skip_block4 u_blk3 (.a(r_op1_hi[7:4]),      .b(r_nop2_hi[7:4]), .cin(w_c12),
                             .sum(w_sum_hi[7:4]),    .cout(w_c16));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid_a <= 1'b0;
         r_res_lo  <= '0;
         r_c8      <= 1'b0;
         r_op1_hi  <= '0;
         r_nop2_hi <= '0;
      end else if (w_load_a) begin
         r_valid_a <= bus.in_valid;
         if (bus.in_valid) begin
            r_res_lo  <= w_sum_lo;
            r_c8      <= w_c8;
            r_op1_hi  <= bus.operand1[c_DATA_W-1:c_SPLIT];
            r_nop2_hi <= w_nop2[c_DATA_W-1:c_SPLIT];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid_b <= 1'b0;
         r_result  <= '0;
         r_borrow  <= 1'b0;
      end else if (w_load_b) begin
         r_valid_b <= r_valid_a;
         if (r_valid_a) begin
            r_result <= {w_sum_hi, r_res_lo};
            r_borrow <= ~w_c16;
         end
      end
   end

`ifdef SUB_OVERFLOW_EN
   logic r_ovf;
   logic w_ovf;

   // Operand signs differ and the result sign disagrees with the minuend.
   assign w_ovf = (r_op1_hi[c_SPLIT-1] != ~r_nop2_hi[c_SPLIT-1]) &&
                  (w_sum_hi[c_SPLIT-1] != r_op1_hi[c_SPLIT-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ovf <= 1'b0;
      else if (w_load_b && r_valid_a)
         r_ovf <= w_ovf;
   end

   assign bus.Overflow = r_ovf;
`endif

   assign bus.in_ready  = w_load_a;
   assign bus.out_valid = r_valid_b;
   assign bus.Result    = r_result;
   assign bus.Borrow    = r_borrow;
endmodule

`default_nettype wire

// File: tb/tb_pipelined_skip_subtractor.sv
// ============================================================================
// Module   : tb_pipelined_skip_subtractor
// Brief    : Vector table plus scoreboard bench for the pipelined carry-skip subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_skip_subtractor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipelined_skip_subtractor_if bus ();
   pipelined_skip_subtractor dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [15:0] op1;
      logic [15:0] op2;
      logic [15:0] res;
      logic        brw;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic        brw;
      logic        ovf;
   } exp_t;

   vec_t vecs[12];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic stalled = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e.res = a - b;
      e.brw = (a < b);
      e.ovf = (a[15] != b[15]) && (e.res[15] != a[15]);
      return e;
   endfunction

   // Entered and left at posedge+1; handshake sampled at posedge+2.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.operand1 = a;
      bus.operand2 = b;
      #1;
      if (!bus.in_ready) stalled = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      if (!bus.in_ready) begin
         chk("send_timeout", 32'(bus.in_ready), 32'd1);
      end else begin
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Output monitor: scoreboard compare on accept, stability check while stalled.
   logic        held = 1'b0;
   logic [15:0] held_res;
   logic        held_brw;
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held && bus.out_valid) begin
            chk("hold_result", 32'(bus.Result), 32'(held_res));
            chk("hold_borrow", 32'(bus.Borrow), 32'(held_brw));
         end
         held = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 32'(bus.out_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", 32'(bus.Result), 32'(e.res));
               chk("borrow", 32'(bus.Borrow), 32'(e.brw));
`ifdef SUB_OVERFLOW_EN
               chk("overflow", 32'(bus.Overflow), 32'(e.ovf));
`endif
            end
         end else if (bus.out_valid) begin
            held     = 1'b1;
            held_res = bus.Result;
            held_brw = bus.Borrow;
         end
      end
   end

   initial begin
      vecs[0]  = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
      vecs[1]  = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
      vecs[2]  = '{16'hA0A0, 16'hA0A0, 16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
      vecs[4]  = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
      vecs[5]  = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
      vecs[6]  = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
      vecs[7]  = '{16'h0100, 16'h00FF, 16'h0001, 1'b0, 1'b0};
      vecs[8]  = '{16'h00F0, 16'h0F00, 16'hF1F0, 1'b1, 1'b0};
      vecs[9]  = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0};
      vecs[10] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};
      vecs[11] = '{16'h1111, 16'h2222, 16'hEEEF, 1'b1, 1'b0};

      bus.in_valid  = 1'b0;
      bus.operand1  = '0;
      bus.operand2  = '0;
      bus.out_ready = 1'b1;
      #1;
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_result",    32'(bus.Result),    32'd0);
      chk("reset_borrow",    32'(bus.Borrow),    32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;

      // Two-cycle latency and single-cycle valid pulse
      send(16'h1234, 16'h0234, '{16'h1000, 1'b0, 1'b0});
      chk("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_cycle2_result", 32'(bus.Result), 32'h1000);
      @(posedge clk); #1;
      chk("lat_pulse_end", 32'(bus.out_valid), 32'd0);
      drain();
      @(posedge clk); #1;

      // Vector table, back to back
      for (int i = 0; i < 12; i++) begin
         exp_t e;
         e.res = vecs[i].res;
         e.brw = vecs[i].brw;
         e.ovf = vecs[i].ovf;
         send(vecs[i].op1, vecs[i].op2, e);
      end
      drain();
      @(posedge clk); #1;

      // Back-to-back four pairs with out_ready low in burst cycles 3..5
      stalled = 1'b0;
      fork
         begin
            for (int c = 0; c < 12; c++) begin
               bus.out_ready = !(c inside {3, 4, 5});
               @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 4; i++) begin
         logic [15:0] a, b;
         a = 16'(16'h3000 + i * 16'h0111);
         b = 16'(16'h1500 + i * 16'h0230);
         send(a, b, model(a, b));
      end
      chk("burst_in_ready_dropped", 32'(stalled), 32'd1);
      drain();
      repeat (10) @(posedge clk);
      #1;

      // Random traffic with random backpressure
      fork
         begin
            for (int c = 0; c < 80; c++) begin
               bus.out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 20; i++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = 16'($urandom);
         send(a, b, model(a, b));
      end
      drain();
      repeat (85) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;

      // Reset with two pairs in flight
      send(16'h4444, 16'h1111, model(16'h4444, 16'h1111));
      send(16'h5555, 16'h2222, model(16'h5555, 16'h2222));
      rst = 1'b1;
      #1;
      chk("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_async_result",    32'(bus.Result),    32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
      send(16'h0000, 16'h0001, '{16'hFFFF, 1'b1, 1'b0});
      chk("rst_lat_cycle1", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      chk("rst_lat_cycle2", 32'(bus.out_valid), 32'd1);
      drain();
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/pipelined_skip_subtractor.md
PIPELINED_SKIP_SUBTRACTOR -- requirements
Module: pipelined_skip_subtractor

Interface
REQ-001 Parameters SHALL be none; width fixed at 16 bits.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair present this cycle.
REQ-005 in_ready  output  1  block accepts operand pair this cycle.
REQ-006 operand1  input  16  minuend, unsigned or two's complement.
REQ-007 operand2  input  16  subtrahend.
REQ-008 out_valid  output  1  Result/Borrow valid.
REQ-009 out_ready  input  1  downstream accepts result this cycle.
REQ-010 Result  output  16  operand1 - operand2 mod 2^16.
REQ-011 Borrow  output  1  1 when operand1 < operand2 unsigned; equals NOT carry-out.
REQ-012 Overflow  output  1  signed overflow; present only per REQ-027.

Function
REQ-013 Subtraction SHALL be computed as operand1 + ~operand2 + 1 using 4-bit carry-skip blocks: skip when all 4 propagate bits are 1, carry-in bypasses to block carry-out.
REQ-014 Stage A SHALL compute bits [7:0] with carry-in 1 (two blocks), register low Result byte, carry into bit 8, operand1[15:8], ~operand2[15:8], and valid_a.
REQ-015 Stage B SHALL compute bits [15:8] (two blocks) from stage-A registers, register full Result, Borrow = ~carry16, valid_b.
REQ-016 Latency SHALL be exactly 2 cycles from input handshake (in_valid & in_ready) to out_valid, given out_ready held 1.
REQ-017 Throughput SHALL be one result per cycle when out_ready stays 1.
REQ-018 out_valid SHALL equal valid_b; Result/Borrow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Stage B SHALL load when !valid_b or out_ready; stage A SHALL load when !valid_a or stage B loads.
REQ-020 in_ready SHALL equal (!valid_a or stage B loads); combinational from out_ready, no combinational path from in_valid.
REQ-021 Simultaneous output accept and input accept SHALL advance both stages in the same cycle with no bubble or loss.
REQ-022 Inputs with in_valid=0 SHALL clear the stage-A valid on load; data registers MAY hold stale values.
REQ-023 Wrap-around: 0x0000 - 0x0001 SHALL give Result 0xFFFF, Borrow 1; equal operands SHALL give 0x0000, Borrow 0.

Reset
REQ-024 On rst=1 valid_a, valid_b, out_valid, Result, Borrow, Overflow SHALL go to 0 immediately, independent of clk.
REQ-025 Reset mid-operation SHALL discard all in-flight pairs; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 in_ready SHALL be 1 while rst=1 is not required; transfers during rst are ignored.

Configuration
REQ-027 Macro SUB_OVERFLOW_EN: defined -> Overflow port exists, registered in stage B as (op1[15] != op2[15]) & (Result[15] != op1[15]), same timing as Result; undefined -> port and logic absent, all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold the data width (16), block width (4) and stage split index (8) constants.
REQ-029 One sub-module carry_skip_block4 (a, b, cin -> sum[3:0], cout) SHALL be instantiated four times; it is purely combinational.
REQ-030 All state SHALL reside in the top module; no latches.

Verification
REQ-031 0x1234 - 0x0234, out_ready=1 -> two cycles later Result 0x1000, Borrow 0, out_valid 1 for one cycle.
REQ-032 0x0000 - 0x0001 -> Result 0xFFFF, Borrow 1; 0xA0A0 - 0xA0A0 -> Result 0x0000, Borrow 0 (full skip chain exercised).
REQ-033 With SUB_OVERFLOW_EN: 0x8000 - 0x0001 -> Result 0x7FFF, Overflow 1; 0x0005 - 0x0003 -> 0x0002, Overflow 0.
REQ-034 Back-to-back 4 pairs, out_ready=0 cycles 3-5 -> in_ready drops once both stages full, no pair lost or duplicated, results in order vs operand1 - operand2 reference model.
REQ-035 rst pulsed while two pairs in flight -> out_valid 0 immediately, no stale result emitted after release, next pair produces correct result at latency 2.
